// File: rtl/cluster_pkg.sv
// Shared types and constants for the cluster packer frame controller.
package cluster_pkg;

  localparam int CLUSTER_W       = 14;
  localparam int ADR_W           = 11;
  localparam int CNT_W           = 3;
  localparam int INVALID_ADR_MIN = 1536;

  localparam logic [CLUSTER_W-1:0] CLUSTER_NULL = {CNT_W'(0), {ADR_W{1'b1}}};

  typedef enum logic [1:0] {
    SEEK,
    ACQUIRE,
    LOCKED
  } state_t;

  // Addresses at or above INVALID_ADR_MIN mark empty packer slots.
  function automatic logic cluster_is_valid(input logic [ADR_W-1:0] adr);
    return adr < ADR_W'(INVALID_ADR_MIN);
  endfunction

endpackage

// File: rtl/cluster_pair_serializer.sv
// Captures one BX worth of clusters and streams them out as four pairs,
// pair (0,1) going straight to the tx registers on the capture edge.
module cluster_pair_serializer
  import cluster_pkg::*;
(
  input  logic                 clock4x,
  input  logic                 reset_n,
  input  logic                 i_capture,
  input  logic                 i_abort,
  input  logic [CLUSTER_W-1:0] i_clusters [8],
  input  logic [11:0]          i_bx,
  output logic [CLUSTER_W-1:0] o_tx_a,
  output logic [CLUSTER_W-1:0] o_tx_b,
  output logic                 o_tx_valid,
  output logic                 o_tx_first,
  output logic [11:0]          o_tx_bx,
  output logic [3:0]           o_tx_cnt,
  output logic                 o_tx_overflow
);

  logic [CLUSTER_W-1:0] r_hold [6];
  logic [1:0]           r_slot;
  logic [CLUSTER_W-1:0] r_tx_a, r_tx_b;
  logic                 r_tx_valid, r_tx_first, r_tx_overflow;
  logic [11:0]          r_tx_bx;
  logic [3:0]           r_tx_cnt;
  logic [3:0]           w_cnt;
  logic [CLUSTER_W-1:0] w_pair_a, w_pair_b;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 8; i++)
      w_cnt = w_cnt + 4'(cluster_is_valid(i_clusters[i][ADR_W-1:0]));
  end

  // r_slot names the next held pair to emit; 0 means no set in flight.
  always_comb begin
    w_pair_a = CLUSTER_NULL;
    w_pair_b = CLUSTER_NULL;
    case (r_slot)
      2'd1: begin w_pair_a = r_hold[0]; w_pair_b = r_hold[1]; end
      2'd2: begin w_pair_a = r_hold[2]; w_pair_b = r_hold[3]; end
      2'd3: begin w_pair_a = r_hold[4]; w_pair_b = r_hold[5]; end
      default: ;
    endcase
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) r_hold[i] <= CLUSTER_NULL;
      r_slot        <= '0;
      r_tx_a        <= CLUSTER_NULL;
      r_tx_b        <= CLUSTER_NULL;
      r_tx_valid    <= 1'b0;
      r_tx_first    <= 1'b0;
      r_tx_bx       <= '0;
      r_tx_cnt      <= '0;
      r_tx_overflow <= 1'b0;
    end else if (i_abort) begin
      r_slot        <= '0;
      r_tx_a        <= CLUSTER_NULL;
      r_tx_b        <= CLUSTER_NULL;
      r_tx_valid    <= 1'b0;
      r_tx_first    <= 1'b0;
      r_tx_bx       <= '0;
      r_tx_cnt      <= '0;
      r_tx_overflow <= 1'b0;
    end else if (i_capture) begin
      for (int i = 0; i < 6; i++) r_hold[i] <= i_clusters[i+2];
      r_slot        <= 2'd1;
      r_tx_a        <= i_clusters[0];
      r_tx_b        <= i_clusters[1];
      r_tx_valid    <= 1'b1;
      r_tx_first    <= 1'b1;
      r_tx_bx       <= i_bx;
      r_tx_cnt      <= w_cnt;
      r_tx_overflow <= (w_cnt == 4'd8);
    end else begin
      r_slot     <= (r_slot == 2'd0) ? 2'd0 : r_slot + 2'd1;
      r_tx_a     <= w_pair_a;
      r_tx_b     <= w_pair_b;
      r_tx_valid <= (r_slot != 2'd0);
      r_tx_first <= 1'b0;
    end
  end

  assign o_tx_a        = r_tx_a;
  assign o_tx_b        = r_tx_b;
  assign o_tx_valid    = r_tx_valid;
  assign o_tx_first    = r_tx_first;
  assign o_tx_bx       = r_tx_bx;
  assign o_tx_cnt      = r_tx_cnt;
  assign o_tx_overflow = r_tx_overflow;

endmodule

// File: rtl/cluster_frame_ctrl.sv
// Locks a 4-phase word counter and BX counter to the BX0 marker and drives
// the cluster pair serializer while locked.
module cluster_frame_ctrl
  import cluster_pkg::*;
#(
  parameter int CAPTURE_PHASE = 2,
  parameter int BX_MAX        = 3563,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                 clock4x,
  input  logic                 reset_n,
  input  logic                 bx0,
  input  logic [CLUSTER_W-1:0] cluster0,
  input  logic [CLUSTER_W-1:0] cluster1,
  input  logic [CLUSTER_W-1:0] cluster2,
  input  logic [CLUSTER_W-1:0] cluster3,
  input  logic [CLUSTER_W-1:0] cluster4,
  input  logic [CLUSTER_W-1:0] cluster5,
  input  logic [CLUSTER_W-1:0] cluster6,
  input  logic [CLUSTER_W-1:0] cluster7,
  output logic [1:0]           phase,
  output logic                 sbit_load,
  output logic                 locked,
  output logic [CLUSTER_W-1:0] tx_a,
  output logic [CLUSTER_W-1:0] tx_b,
  output logic                 tx_valid,
  output logic                 tx_first,
  output logic [11:0]          tx_bx,
  output logic [3:0]           tx_cnt,
  output logic                 tx_overflow,
  output logic [15:0]          err_cnt
);

  state_t               r_state, w_next_state;
  logic [1:0]           r_phase;
  logic [11:0]          r_bx_cnt;
  logic [3:0]           r_good, w_good_next;
  logic [15:0]          r_err_cnt;
  logic                 r_locked;
  logic                 w_aligned, w_error, w_restart;
  logic                 w_capture, w_abort;
  logic [CLUSTER_W-1:0] w_clusters [8];

  assign w_aligned = (r_phase == 2'd0) && (r_bx_cnt == '0);

  // A marker that causes an error is consumed by the error; only a later
  // marker seen in SEEK restarts acquisition.
  always_comb begin
    w_next_state = r_state;
    w_good_next  = r_good;
    w_error      = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      SEEK: begin
        if (bx0) begin
          w_restart    = 1'b1;
          w_good_next  = 4'd1;
          w_next_state = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (bx0 != w_aligned) begin
          w_error = 1'b1;
        end else if (bx0) begin
          w_good_next = r_good + 4'd1;
          if (r_good + 4'd1 == 4'(LOCK_COUNT)) w_next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (bx0 != w_aligned) w_error = 1'b1;
      end
      default: w_next_state = SEEK;
    endcase
    if (w_error) begin
      w_next_state = SEEK;
      w_good_next  = '0;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SEEK;
      r_good    <= '0;
      r_phase   <= '0;
      r_bx_cnt  <= '0;
      r_err_cnt <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_good   <= w_good_next;
      r_locked <= (w_next_state == LOCKED);
      if (w_restart) begin
        r_phase  <= 2'd1;
        r_bx_cnt <= '0;
      end else begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3)
          r_bx_cnt <= (r_bx_cnt == 12'(BX_MAX)) ? '0 : r_bx_cnt + 12'd1;
      end
      if (w_error && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // An error on the capture edge takes precedence: the set is dropped.
  assign w_capture = (r_state == LOCKED) && (w_next_state == LOCKED) &&
                     (r_phase == 2'(CAPTURE_PHASE));
  assign w_abort   = (w_next_state != LOCKED);

  assign w_clusters[0] = cluster0;
  assign w_clusters[1] = cluster1;
  assign w_clusters[2] = cluster2;
  assign w_clusters[3] = cluster3;
  assign w_clusters[4] = cluster4;
  assign w_clusters[5] = cluster5;
  assign w_clusters[6] = cluster6;
  assign w_clusters[7] = cluster7;

  cluster_pair_serializer u_serializer (
    .clock4x       (clock4x),
    .reset_n       (reset_n),
    .i_capture     (w_capture),
    .i_abort       (w_abort),
    .i_clusters    (w_clusters),
    .i_bx          (r_bx_cnt),
    .o_tx_a        (tx_a),
    .o_tx_b        (tx_b),
    .o_tx_valid    (tx_valid),
    .o_tx_first    (tx_first),
    .o_tx_bx       (tx_bx),
    .o_tx_cnt      (tx_cnt),
    .o_tx_overflow (tx_overflow)
  );

  assign phase     = r_phase;
  assign sbit_load = (r_phase == 2'd0);
  assign locked    = r_locked;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/cluster_frame_ctrl.md
# cluster_frame_ctrl

Frame-phase controller and output scheduler for the cluster packer datapath. It runs in the clock4x domain and locks a 4-phase word counter to the BX0 marker. That counter replaces the free-running byte counter that steers S-bit word capture. It then captures the packer's 8 clusters once per BX and streams them out as 2 clusters per clock4x cycle, with frame, BX-ID and occupancy tags. It detects phase misalignment and missing BX0 markers, counts them, and re-acquires lock without software intervention.

## Interface
- CAPTURE_PHASE, 2: phase (0..3) at which packer outputs are sampled; equals packer latency mod 4.
- BX_MAX, 3563: last BX number in an orbit; the BX counter wraps to 0 after it.
- LOCK_COUNT, 4: number of consecutive aligned BX0 markers required to declare lock (1..15).
- clock4x  in  1  4× LHC clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bx0  in  1  orbit marker, one-cycle pulse; valid only in phase 0.
- cluster0..cluster7  in  14 each  packer outputs: [10:0] address, [13:11] size.
- phase  out  2  current word phase; drives S-bit word-capture select.
- sbit_load  out  1  high when phase==0; assembled 64-bit S-bit words load on this cycle.
- locked  out  1  high in LOCKED state.
- tx_a, tx_b  out  14 each  cluster pair for the current slot.
- tx_valid  out  1  pair valid.
- tx_first  out  1  first pair (clusters 0/1) of a BX.
- tx_bx  out  12  BX number of the captured set; held for all 4 slots.
- tx_cnt  out  4  number of valid clusters in the set (0..8); meaningful with tx_first.
- tx_overflow  out  1  tx_cnt==8; meaningful with tx_first.
- err_cnt  out  16  saturating count of alignment errors.

## Operation
- Cluster validity: a cluster is valid iff address < 1536. Null cluster = CLUSTER_NULL = {3'd0, 11'h7FF}.
- phase increments every cycle, 3→0. bx_cnt increments when phase==3, wraps from BX_MAX to 0.
- States:
  - SEEK (reset state). On bx0: phase←1, bx_cnt←0, good←1, go to ACQUIRE; if LOCK_COUNT==1 go directly to LOCKED.
  - ACQUIRE. When phase==0 and bx_cnt==0: bx0 present → good+1, LOCKED when good reaches LOCK_COUNT; bx0 absent → error.
  - LOCKED. When phase==0 and bx_cnt==0 with bx0 absent → error.
- Error, from any state other than SEEK, covers:
  - bx0 arriving when (phase,bx_cnt) ≠ (0,0);
  - a missing bx0 in ACQUIRE or LOCKED.
- Error response: err_cnt+1 (saturates at 16'hFFFF), go to SEEK, good←0.
- A bx0 that causes an error is not reused for acquisition. A later bx0 in SEEK restarts acquisition.
- Scheduler, LOCKED only:
  - On the edge where phase==CAPTURE_PHASE, register cluster0..7, bx_cnt, and the valid count.
  - Over the following 4 cycles, emit pairs (0,1), (2,3), (4,5), (6,7) with tx_valid=1. tx_first=1 on pair (0,1) only.
  - Result: a continuous stream of 4 slots per BX.
- Leaving LOCKED aborts the current set. Remaining slots are not emitted.

## Timing
- Reset values: phase=0, sbit_load=1 (combinational from phase), bx_cnt=0, locked=0, tx_valid=0, tx_first=0, tx_a=tx_b=CLUSTER_NULL, tx_bx=0, tx_cnt=0, tx_overflow=0, err_cnt=0.
- All outputs except sbit_load are registered.
- Capture-to-output latency: pair (0,1) appears 1 cycle after the capture edge.
- Lock: locked rises 1 cycle after the edge that samples the LOCK_COUNT-th aligned bx0.
- Error: locked and tx_valid fall 1 cycle after the error edge. err_cnt updates on the same cycle.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Operation resumes in SEEK on the first edge after reset_n deasserts.
- Simultaneous misaligned bx0 and capture edge: the error wins; nothing is emitted.
- Outside LOCKED: tx_valid=0 and tx_a/tx_b=CLUSTER_NULL.

## Structure
- Shared package cluster_pkg:
  - CLUSTER_W=14, ADR_W=11, CNT_W=3;
  - CLUSTER_NULL, INVALID_ADR_MIN=1536;
  - function cluster_is_valid;
  - state enum {SEEK, ACQUIRE, LOCKED}.
- One sub-module, cluster_pair_serializer: capture registers, valid-count popcount, 4-slot pair mux, tx_* registers. Ports: capture, abort, the 8 clusters, bx.
- FSM, phase counter, BX counter and error counter live in the top level.

## Test plan
All scenarios use BX_MAX=7, LOCK_COUNT=2, CAPTURE_PHASE=2.

- Acquisition: bx0 every 32 cycles starting at cycle 10 → locked=1 after the 2nd bx0; tx_valid continuous from then; tx_bx steps 0..7 and wraps.
- Data path: cluster0=14'h0005, cluster1=14'h1A00, cluster7=14'h0010, others CLUSTER_NULL, held stable, while locked → tx_first slot gives tx_a=0x0005, tx_b=0x1A00, tx_cnt=3; the 4th slot gives tx_b=0x0010; tx_overflow=0.
- Overflow: all 8 clusters at address 100 → tx_cnt=8, tx_overflow=1.
- Misalignment: while locked, shift bx0 by +1 cycle → err_cnt=1, locked=0 and tx_valid=0 the next cycle; relock after 2 aligned markers at the new phase.
- Missing marker: suppress one bx0 while locked → err_cnt increments once; a single marker leaves locked low; a second marker restores locked.
- Reset/saturation: assert reset_n low mid-slot → outputs at reset values immediately. Force err_cnt to 16'hFFFF and inject an error → err_cnt stays 16'hFFFF.
